inst_cache: RTL and testbench
=============================

# inst_cache

Direct-mapped, read-only instruction cache between the fetch queue's memory-side port and the backing memory. It accepts one word-fetch at a time from the fetch queue, returns hits one cycle after acceptance, and refills missing lines from memory one word per beat. Responses carry their address because the fetch queue discards responses whose address does not match its outstanding request.

## Interface
- LINES, 64, number of cache lines (power of two, ≥2)
- WORDS_PER_LINE, 4, 32-bit words per line (power of two, ≥2)

- clk  input  1  clock
- rst_n  input  1  asynchronous, active-low reset
- memreq_valid  input  1  fetch-queue request valid
- memreq_ready  output  1  cache can accept a request this cycle
- memreq_addr  input  32  byte address; bits [1:0] ignored
- memresp_valid  output  1  one-cycle response pulse
- memresp_addr  output  32  address of the accepted request, [1:0] forced to 0
- memresp_inst  output  32  instruction word
- invalidate  input  1  clear all valid bits (fence.i)
- mem_req_valid  output  1  backing-memory word read request
- mem_req_ready  input  1  backing memory accepts request
- mem_req_addr  output  32  word-aligned refill address
- mem_resp_valid  input  1  backing-memory data valid
- mem_resp_data  input  32  refill word

## Operation
- Address split: offset = [log2(WORDS_PER_LINE)+1:2], index = next log2(LINES) bits, tag = remaining upper bits.
- States: IDLE, REFILL_REQ, REFILL_WAIT, RESPOND.
- IDLE: memreq_ready=1. Accept on memreq_valid&&memreq_ready; latch address; lookup completes next cycle.
- Lookup (cycle after accept, still IDLE): hit → memresp_valid=1 with the cached word, ready stays 1, so a new request may be accepted in the same cycle (back-to-back hits, one per cycle). Miss → memresp_valid=0, memreq_ready=0 this cycle, go REFILL_REQ with beat counter=0.
- REFILL_REQ: mem_req_valid=1, mem_req_addr = {tag,index,beat,2'b00}; on mem_req_ready → REFILL_WAIT.
- REFILL_WAIT: on mem_resp_valid write word to line buffer slot beat; beat==WORDS_PER_LINE-1 → write tag/data, set valid, → RESPOND; else beat+1, → REFILL_REQ. Only one memory request outstanding.
- RESPOND: memresp_valid=1 with requested word from line buffer; memreq_ready=0; → IDLE.
- Responses are never held; the consumer has no ready. An abandoned request (consumer redirected) still completes; its response is emitted and discarded by address mismatch.
- invalidate: clears every valid bit at the next edge. If asserted with a lookup pending, that lookup is a miss. If asserted during REFILL_*/RESPOND, the refilled line is written but left invalid; the pending response is still delivered.
- memreq_valid while ready=0 is ignored, not queued.

## Timing
- Reset (async assert): state IDLE, all valid bits 0, beat 0, memreq_ready=1, memresp_valid=0, memresp_addr=0, memresp_inst=0, mem_req_valid=0, mem_req_addr=0. Reset mid-refill aborts the refill; no line becomes valid.
- Hit latency: accept edge N, memresp_valid in cycle N+1.
- Miss latency: N+1 lookup, then per beat 1 request cycle (plus mem_req_ready stall) + memory latency; RESPOND one cycle after the last data beat.
- mem_req_valid held with stable address until mem_req_ready.
- mem_resp_valid outside REFILL_WAIT is ignored.

## Structure
- Package inst_cache_pkg: state enum, address-field width localparams derived from LINES/WORDS_PER_LINE, tag/index/offset extract functions.
- Sub-module inst_cache_array: valid bits (async-reset), tag and data arrays with one registered read port and one line write port plus global valid clear. Controller FSM in inst_cache.

## Test plan
- Cold miss 0x0000_0100, memory returns 0x13,0x93,0x113,0x193 for line words, 1-cycle latency → one RESPOND pulse addr 0x100 inst 0x13; exactly 4 mem requests at 0x100,0x104,0x108,0x10C.
- After that, requests 0x104,0x108,0x10C back-to-back → responses in consecutive cycles, each one cycle after accept, no mem traffic.
- Conflict: fill 0x100, then access 0x100+LINES*16 → miss, refill; then 0x100 again → miss.
- invalidate pulse, then 0x104 → miss and refill; invalidate asserted during refill of 0x200 → response at 0x200 delivered, next 0x204 misses.
- mem_req_ready low for 3 cycles on beat 2 → mem_req_addr stable, memreq_ready stays 0, correct data afterwards.
- rst_n asserted during REFILL_WAIT beat 1 → all outputs at reset values immediately; subsequent access to same line misses and refills fully.

Source files
------------

// File: rtl/inst_cache_pkg.sv
// rtl/inst_cache_pkg.sv - inst_cache shared types, default geometry and address-field helpers.
package inst_cache_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REFILL_REQ,
    S_REFILL_WAIT,
    S_RESPOND
  } state_e;

  localparam int DEF_LINES = 64;
  localparam int DEF_WORDS = 4;
  localparam int DEF_OFF_W = $clog2(DEF_WORDS);
  localparam int DEF_IDX_W = $clog2(DEF_LINES);
  localparam int DEF_TAG_W = 30 - DEF_OFF_W - DEF_IDX_W;

  function automatic logic [31:0] get_offset(input logic [31:0] addr, input int off_w);
    return (addr >> 2) & ((32'd1 << off_w) - 32'd1);
  endfunction

  function automatic logic [31:0] get_index(input logic [31:0] addr, input int off_w,
                                            input int idx_w);
    return (addr >> (2 + off_w)) & ((32'd1 << idx_w) - 32'd1);
  endfunction

  function automatic logic [31:0] get_tag(input logic [31:0] addr, input int off_w,
                                          input int idx_w);
    return addr >> (2 + off_w + idx_w);
  endfunction

endpackage

// File: rtl/inst_cache_array.sv
// rtl/inst_cache_array.sv - valid/tag/data storage with one registered read port and one line write port.
module inst_cache_array
  import inst_cache_pkg::*;
#(
  parameter int LINES = DEF_LINES,
  parameter int WORDS = DEF_WORDS,
  parameter int IW    = DEF_IDX_W,
  parameter int TW    = DEF_TAG_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_en_i,
  input  logic [IW-1:0]         rd_idx_i,
  output logic                  rd_valid_o,
  output logic [TW-1:0]         rd_tag_o,
  output logic [WORDS*32-1:0]   rd_line_o,
  input  logic                  wr_en_i,
  input  logic [IW-1:0]         wr_idx_i,
  input  logic [TW-1:0]         wr_tag_i,
  input  logic [WORDS*32-1:0]   wr_line_i,
  input  logic                  wr_valid_i,
  input  logic                  clear_i
);

  logic [LINES-1:0]    valid_q;
  logic                rd_valid_q;
  logic [TW-1:0]       tag_mem [LINES];
  logic [WORDS*32-1:0] data_mem [LINES];
  logic [TW-1:0]       rd_tag_q;
  logic [WORDS*32-1:0] rd_line_q;

  // A clear in the read cycle also kills the sampled valid, so that lookup misses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      if (clear_i) begin
        valid_q <= '0;
      end else if (wr_en_i) begin
        valid_q[wr_idx_i] <= wr_valid_i;
      end
      if (rd_en_i) begin
        rd_valid_q <= valid_q[rd_idx_i] && !clear_i;
      end else if (clear_i) begin
        rd_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_mem[wr_idx_i]  <= wr_tag_i;
      data_mem[wr_idx_i] <= wr_line_i;
    end
    if (rd_en_i) begin
      rd_tag_q  <= tag_mem[rd_idx_i];
      rd_line_q <= data_mem[rd_idx_i];
    end
  end

  assign rd_valid_o = rd_valid_q;
  assign rd_tag_o   = rd_tag_q;
  assign rd_line_o  = rd_line_q;

endmodule

// File: rtl/inst_cache.sv
// rtl/inst_cache.sv - direct-mapped read-only instruction cache with word-per-beat line refill.
module inst_cache
  import inst_cache_pkg::*;
#(
  parameter int LINES          = DEF_LINES,
  parameter int WORDS_PER_LINE = DEF_WORDS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        memreq_valid,
  output logic        memreq_ready,
  input  logic [31:0] memreq_addr,
  output logic        memresp_valid,
  output logic [31:0] memresp_addr,
  output logic [31:0] memresp_inst,
  input  logic        invalidate,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data
);

  localparam int OW = $clog2(WORDS_PER_LINE);
  localparam int IW = $clog2(LINES);
  localparam int TW = 30 - OW - IW;
  localparam logic [OW-1:0] LAST_BEAT = OW'(WORDS_PER_LINE - 1);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        lookup_q, lookup_d;
  logic [OW-1:0] beat_q, beat_d;
  logic        inval_q, inval_d;
  logic [31:0] buf_q [WORDS_PER_LINE];

  logic                         accept;
  logic                         hit;
  logic                         line_wr;
  logic [OW-1:0]                req_off;
  logic [IW-1:0]                req_idx;
  logic [IW-1:0]                in_idx;
  logic [TW-1:0]                req_tag;
  logic                         rd_valid;
  logic [TW-1:0]                rd_tag;
  logic [WORDS_PER_LINE*32-1:0] rd_line;
  logic [WORDS_PER_LINE*32-1:0] fill_line;

  assign req_off = OW'(get_offset(addr_q, OW));
  assign req_idx = IW'(get_index(addr_q, OW, IW));
  assign req_tag = TW'(get_tag(addr_q, OW, IW));
  assign in_idx  = IW'(get_index(memreq_addr, OW, IW));
  assign accept  = memreq_valid && memreq_ready;
  assign hit     = rd_valid && (rd_tag == req_tag) && !invalidate;
  assign memresp_addr = addr_q;

  // The final beat goes straight into the array alongside the buffered beats.
  always_comb begin
    fill_line = '0;
    for (int i = 0; i < WORDS_PER_LINE; i++) begin
      fill_line[i*32 +: 32] = (OW'(i) == beat_q) ? mem_resp_data : buf_q[i];
    end
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    lookup_d      = 1'b0;
    beat_d        = beat_q;
    inval_d       = inval_q || invalidate;
    line_wr       = 1'b0;
    memreq_ready  = 1'b0;
    memresp_valid = 1'b0;
    memresp_inst  = '0;
    mem_req_valid = 1'b0;
    mem_req_addr  = '0;
    case (state_q)
      S_IDLE: begin
        inval_d      = 1'b0;
        memreq_ready = !(lookup_q && !hit);
        if (lookup_q) begin
          if (hit) begin
            memresp_valid = 1'b1;
            memresp_inst  = rd_line[{req_off, 5'd0} +: 32];
          end else begin
            state_d = S_REFILL_REQ;
            beat_d  = '0;
          end
        end
        if (accept) begin
          addr_d   = memreq_addr & ~32'd3;
          lookup_d = 1'b1;
        end
      end
      S_REFILL_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {addr_q[31:OW+2], beat_q, 2'b00};
        if (mem_req_ready) state_d = S_REFILL_WAIT;
      end
      S_REFILL_WAIT: begin
        if (mem_resp_valid) begin
          if (beat_q == LAST_BEAT) begin
            line_wr = 1'b1;
            state_d = S_RESPOND;
          end else begin
            beat_d  = beat_q + 1'b1;
            state_d = S_REFILL_REQ;
          end
        end
      end
      S_RESPOND: begin
        memresp_valid = 1'b1;
        memresp_inst  = buf_q[req_off];
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      lookup_q <= 1'b0;
      beat_q   <= '0;
      inval_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      lookup_q <= lookup_d;
      beat_q   <= beat_d;
      inval_q  <= inval_d;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == S_REFILL_WAIT && mem_resp_valid) begin
      buf_q[beat_q] <= mem_resp_data;
    end
  end

  // A line refilled across an invalidate is stored but stays invalid.
  inst_cache_array #(
    .LINES (LINES),
    .WORDS (WORDS_PER_LINE),
    .IW    (IW),
    .TW    (TW)
  ) u_array (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_en_i    (accept),
    .rd_idx_i   (in_idx),
    .rd_valid_o (rd_valid),
    .rd_tag_o   (rd_tag),
    .rd_line_o  (rd_line),
    .wr_en_i    (line_wr),
    .wr_idx_i   (req_idx),
    .wr_tag_i   (req_tag),
    .wr_line_i  (fill_line),
    .wr_valid_i (!inval_q),
    .clear_i    (invalidate)
  );

endmodule

// File: tb/tb_inst_cache.sv
// tb/tb_inst_cache.sv - self-checking bench for inst_cache against a line-level cache model.
module tb_inst_cache;

  localparam int LINES = 64;
  localparam int WPL   = 4;

  logic        clk;
  logic        rst_n;
  logic        memreq_valid;
  logic        memreq_ready;
  logic [31:0] memreq_addr;
  logic        memresp_valid;
  logic [31:0] memresp_addr;
  logic [31:0] memresp_inst;
  logic        invalidate;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  inst_cache #(.LINES(LINES), .WORDS_PER_LINE(WPL)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .memreq_valid   (memreq_valid),
    .memreq_ready   (memreq_ready),
    .memreq_addr    (memreq_addr),
    .memresp_valid  (memresp_valid),
    .memresp_addr   (memresp_addr),
    .memresp_inst   (memresp_inst),
    .invalidate     (invalidate),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] memword(input logic [31:0] a);
    return 32'h13 + ((a - 32'h100) << 5);
  endfunction

  // Model: which memory line each cache slot holds, and the expected traffic.
  typedef struct {
    logic [31:0] addr;
    logic [31:0] inst;
    int          due;
  } resp_t;

  bit          m_valid [LINES];
  logic [31:0] m_line  [LINES];
  resp_t       exp_resp[$];
  logic [31:0] exp_mreq[$];
  int          model_stall = 0;
  int          hs_count = 0;
  logic [31:0] last_inst = '0;
  logic [31:0] last_addr = '0;

  task automatic model_accept(input logic [31:0] a, input int acc);
    logic [31:0] wa, line;
    int idx;
    resp_t r;
    wa   = a & ~32'd3;
    line = wa / (WPL * 4);
    idx  = int'(line % LINES);
    r.addr = wa;
    r.inst = memword(wa);
    if (m_valid[idx] && m_line[idx] == line) begin
      r.due = acc + 1;
    end else begin
      r.due = acc + 2 + 2 * WPL + model_stall;
      model_stall = 0;
      for (int b = 0; b < WPL; b++) exp_mreq.push_back(line * WPL * 4 + b * 4);
      m_valid[idx] = 1'b1;
      m_line[idx]  = line;
    end
    exp_resp.push_back(r);
  endtask

  task automatic model_clear();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
  endtask

  // Compare process: every response pulse and every refill request handshake/stall.
  always @(negedge clk) begin
    if (rst_n && memresp_valid) begin
      if (exp_resp.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL resp_unexpected actual_addr=%h expected=none", memresp_addr);
      end else begin
        resp_t e;
        e = exp_resp.pop_front();
        check("resp_addr", memresp_addr, e.addr);
        check("resp_inst", memresp_inst, e.inst);
        check("resp_cycle", cyc, e.due);
      end
      last_inst = memresp_inst;
      last_addr = memresp_addr;
    end
  end

  always @(posedge clk) begin
    if (rst_n && mem_req_valid) begin
      if (exp_mreq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL mreq_unexpected actual_addr=%h expected=none", mem_req_addr);
      end else if (mem_req_ready) begin
        hs_count++;
        check("mreq_addr", mem_req_addr, exp_mreq.pop_front());
      end else begin
        check("mreq_stall_addr", mem_req_addr, exp_mreq[0]);
      end
    end
  end

  // Backing memory: one-cycle read latency, optional ready stall on one address.
  logic [31:0] stall_addr = 32'hFFFF_FFFF;
  int          stall_left = 0;
  bit          hs_next = 1'b0;
  logic [31:0] hs_addr = '0;

  always @(negedge clk) begin
    mem_resp_valid = hs_next;
    mem_resp_data  = hs_next ? memword(hs_addr) : 32'hDEAD_BEEF;
    mem_req_ready  = 1'b1;
    if (mem_req_valid && mem_req_addr == stall_addr && stall_left > 0) begin
      mem_req_ready = 1'b0;
      stall_left--;
      check("stall_memreq_ready", {31'd0, memreq_ready}, 32'd0);
    end
    hs_next = rst_n && mem_req_valid && mem_req_ready;
    hs_addr = mem_req_addr;
  end

  int acc_cyc = 0;

  task automatic fetch(input logic [31:0] a);
    int n;
    memreq_valid = 1'b1;
    memreq_addr  = a;
    n = 0;
    while (!memreq_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL fetch_timeout actual=not_ready required=ready addr=%h", a);
    end else begin
      acc_cyc = cyc;
      model_accept(a, cyc);
    end
    @(negedge clk);
    memreq_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_resp.size() != 0 || exp_mreq.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 300) begin
      failures++;
      $display("FAIL idle_timeout actual=busy required=idle resp=%0d mreq=%0d",
               exp_resp.size(), exp_mreq.size());
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_memreq_ready"}, {31'd0, memreq_ready}, 32'd1);
    check({tag, "_memresp_valid"}, {31'd0, memresp_valid}, 32'd0);
    check({tag, "_memresp_addr"}, memresp_addr, 32'd0);
    check({tag, "_memresp_inst"}, memresp_inst, 32'd0);
    check({tag, "_mem_req_valid"}, {31'd0, mem_req_valid}, 32'd0);
    check({tag, "_mem_req_addr"}, mem_req_addr, 32'd0);
  endtask

  initial begin
    int a_first;
    rst_n        = 1'b0;
    memreq_valid = 1'b0;
    memreq_addr  = '0;
    invalidate   = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    fetch(32'h100);
    wait_idle();
    check("cold_hs_count", hs_count, 32'd4);
    check("cold_inst", last_inst, 32'h13);
    check("cold_addr", last_addr, 32'h100);

    fetch(32'h104);
    a_first = acc_cyc;
    fetch(32'h108);
    fetch(32'h10E);
    wait_idle();
    check("b2b_accept_span", acc_cyc - a_first, 32'd2);
    check("b2b_hs_count", hs_count, 32'd4);
    check("b2b_last_inst", last_inst, 32'h193);
    check("b2b_last_addr", last_addr, 32'h10C);

    fetch(32'h100 + LINES * 16);
    wait_idle();
    fetch(32'h100);
    wait_idle();
    check("conflict_hs_count", hs_count, 32'd12);

    invalidate = 1'b1;
    model_clear();
    @(negedge clk);
    invalidate = 1'b0;
    fetch(32'h104);
    wait_idle();
    check("inval_hs_count", hs_count, 32'd16);

    fetch(32'h200);
    repeat (2) @(negedge clk);
    invalidate = 1'b1;
    model_clear();
    @(negedge clk);
    invalidate = 1'b0;
    wait_idle();
    check("inval_refill_inst", last_inst, 32'h2013);
    fetch(32'h204);
    wait_idle();
    check("inval_refill_hs_count", hs_count, 32'd24);

    stall_addr  = 32'h308;
    stall_left  = 3;
    model_stall = 3;
    fetch(32'h300);
    wait_idle();
    check("stall_consumed", stall_left, 32'd0);
    fetch(32'h308);
    wait_idle();
    check("stall_hs_count", hs_count, 32'd28);

    fetch(32'h400);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrefill_reset");
    model_clear();
    exp_resp.delete();
    exp_mreq.delete();
    check("reset_hs_count", hs_count, 32'd30);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fetch(32'h400);
    wait_idle();
    check("after_reset_hs_count", hs_count, 32'd34);
    check("after_reset_addr", last_addr, 32'h400);

    check("resp_queue_empty", exp_resp.size(), 32'd0);
    check("mreq_queue_empty", exp_mreq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
